// File: rtl/fetch_decode_pipe_pkg.sv
// fetch_decode_pipe_pkg
//   Shared definitions for the fetch/decode pipeline boundary: the FSM state
//   encoding and the default bubble instruction.
package fetch_decode_pipe_pkg;

  // RUN   : decode advances normally
  // STALL : decode registers are frozen by the stall unit
  // DROP  : the cycle after a flush, in-flight I-memory responses are stale
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DROP  = 2'd2
  } fdState_e;

  // Canonical RISC-V nop (addi x0, x0, 0) used as the decode bubble.
  localparam logic [31:0] DEFAULT_NOP = 32'h00000013;

endpackage

// File: rtl/fd_skid_fifo.sv
// fd_skid_fifo
//   Two-entry skid buffer between the I-memory response and the decode
//   registers. Entries are opaque WIDTH-bit words ({instruction, pc}).
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset, empties the buffer
//   clear_i     synchronous flush of all entries (dominates push/pop)
//   push_i      enqueue pushData_i
//   pushData_i  entry to enqueue
//   pop_i       dequeue the head entry
//   count_o     occupancy, 0..2
//   head_o      oldest entry (only meaningful when count_o != 0)
//   overflow_o  a push was rejected this cycle because the buffer was full
module fd_skid_fifo #(
  parameter int WIDTH = 52
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic [WIDTH-1:0] head_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rdPtr_q;
  logic             wrPtr_q;
  logic [1:0]       count_q;
  logic             popOk;
  logic             pushOk;

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign popOk      = pop_i & (count_q != 2'd0);
  assign pushOk     = push_i & ((count_q != 2'd2) | popOk);
  assign overflow_o = push_i & ~pushOk & ~clear_i;
  assign count_o    = count_q;
  assign head_o     = mem_q[rdPtr_q];

  // Storage is pure datapath; occupancy tracking decides what is valid.
  always_ff @(posedge clock) begin
    if (pushOk && !clear_i) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

  // One-bit pointers wrap naturally modulo 2.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else if (clear_i) begin
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (pushOk) begin
        wrPtr_q <= ~wrPtr_q;
      end
      if (popOk) begin
        rdPtr_q <= ~rdPtr_q;
      end
      case ({pushOk, popOk})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_decode_pipe.sv
// fetch_decode_pipe
//   Fetch-to-decode pipeline register with a two-entry skid buffer so that
//   I-memory responses arriving during a decode stall are not lost, plus a
//   one-cycle drop window after a flush to discard stale responses.
//
// Configuration macro
//   FETCH_DECODE_STATS_EN  when defined, stall_cycles / flush_count are
//                          saturating counters; otherwise they tie to 0.
//
// Ports
//   clock, reset          clock and asynchronous active-low reset
//   stall_decode          hold the decode registers this cycle
//   flush_decode          squash decode and the skid buffer
//   inst_valid            I-memory response valid
//   inst_fetch, pc_inst   I-memory instruction and its PC
//   instruction_decode    registered instruction to decode
//   pc_decode             registered PC to decode
//   valid_decode          decode holds a real instruction
//   fetch_hold            fetch must not issue a new request
//   i_mem_hazard          nothing available for decode this cycle
//   overflow              sticky skid-buffer overflow
//   stall_cycles          stall statistics counter
//   flush_count           flush statistics counter
module fetch_decode_pipe
  import fetch_decode_pipe_pkg::*;
#(
  parameter int          CORE         = 0,
  parameter int          ADDRESS_BITS = 20,
  parameter logic [31:0] NOP          = DEFAULT_NOP
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall_decode,
  input  logic                    flush_decode,
  input  logic                    inst_valid,
  input  logic [31:0]             inst_fetch,
  input  logic [ADDRESS_BITS-1:0] pc_inst,
  output logic [31:0]             instruction_decode,
  output logic [ADDRESS_BITS-1:0] pc_decode,
  output logic                    valid_decode,
  output logic                    fetch_hold,
  output logic                    i_mem_hazard,
  output logic                    overflow,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             flush_count
);

  localparam int FIFO_W = 32 + ADDRESS_BITS;

  // The core index only identifies the instance; reject nonsense values early.
  if (CORE < 0) begin : gBadCore
    $error("fetch_decode_pipe: CORE must be non-negative");
  end

  fdState_e                state_q, state_d;
  logic [31:0]             decodeInst_q, decodeInst_d;
  logic [ADDRESS_BITS-1:0] decodePc_q, decodePc_d;
  logic                    decodeValid_q, decodeValid_d;
  logic                    overflow_q;

  logic [FIFO_W-1:0]       fifoHead;
  logic [1:0]              fifoCount;
  logic                    fifoPush;
  logic                    fifoPop;
  logic                    fifoClear;
  logic                    fifoReject;
  logic                    effValid;
  logic                    advance;
  logic [31:0]             headInst;
  logic [ADDRESS_BITS-1:0] headPc;

  // Responses arriving in the cycle after a flush belong to the squashed path.
  assign effValid  = inst_valid & (state_q != DROP);
  assign advance   = ~flush_decode & ~stall_decode;
  assign fifoClear = flush_decode;
  assign fifoPop   = advance & (fifoCount != 2'd0);
  // When the buffer is empty on an advance the response bypasses it.
  assign fifoPush  = ~flush_decode & effValid & (stall_decode | (fifoCount != 2'd0));

  assign headInst  = fifoHead[FIFO_W-1 -: 32];
  assign headPc    = fifoHead[ADDRESS_BITS-1:0];

  fd_skid_fifo #(
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (fifoClear),
    .push_i     (fifoPush),
    .pushData_i ({inst_fetch, pc_inst}),
    .pop_i      (fifoPop),
    .count_o    (fifoCount),
    .head_o     (fifoHead),
    .overflow_o (fifoReject)
  );

  // Next state and next decode contents. Flush beats stall; every state
  // uses the same transition rule, DROP only differs in ignoring inst_valid.
  always_comb begin
    state_d       = state_q;
    decodeInst_d  = decodeInst_q;
    decodePc_d    = decodePc_q;
    decodeValid_d = decodeValid_q;
    if (flush_decode) begin
      state_d       = DROP;
      decodeInst_d  = NOP;
      decodePc_d    = '0;
      decodeValid_d = 1'b0;
    end else if (stall_decode) begin
      state_d = STALL;
    end else begin
      state_d = RUN;
      if (fifoCount != 2'd0) begin
        decodeInst_d  = headInst;
        decodePc_d    = headPc;
        decodeValid_d = 1'b1;
      end else if (effValid) begin
        decodeInst_d  = inst_fetch;
        decodePc_d    = pc_inst;
        decodeValid_d = 1'b1;
      end else begin
        decodeInst_d  = NOP;
        decodePc_d    = '0;
        decodeValid_d = 1'b0;
      end
    end
  end

  // FSM state, decode registers and the sticky overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      decodeInst_q  <= NOP;
      decodePc_q    <= '0;
      decodeValid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      decodeInst_q  <= decodeInst_d;
      decodePc_q    <= decodePc_d;
      decodeValid_q <= decodeValid_d;
      if (fifoReject) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign instruction_decode = decodeInst_q;
  assign pc_decode          = decodePc_q;
  assign valid_decode       = decodeValid_q;
  assign overflow           = overflow_q;

  assign fetch_hold   = stall_decode | (fifoCount != 2'd0) | (state_q == DROP);
  assign i_mem_hazard = (state_q == RUN) & ~stall_decode & (fifoCount == 2'd0) & ~inst_valid;

`ifdef FETCH_DECODE_STATS_EN
  logic [31:0] stallCycles_q;
  logic [31:0] flushCount_q;

  // Saturating counters so a long run never wraps back to small values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stallCycles_q <= '0;
      flushCount_q  <= '0;
    end else begin
      if (stall_decode && (stallCycles_q != 32'hFFFFFFFF)) begin
        stallCycles_q <= stallCycles_q + 32'd1;
      end
      if (flush_decode && (flushCount_q != 32'hFFFFFFFF)) begin
        flushCount_q <= flushCount_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stallCycles_q;
  assign flush_count  = flushCount_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// tb_fetch_decode_pipe
//   Scoreboard bench for fetch_decode_pipe. Instructions the pipe must
//   eventually present are queued as they are driven and popped in order
//   each time decode advances.
module tb_fetch_decode_pipe;
  import fetch_decode_pipe_pkg::*;

  localparam int          AB   = 20;
  localparam logic [31:0] NOPI = 32'h00000013;

  typedef struct packed {
    logic [31:0]   inst;
    logic [AB-1:0] pc;
  } entry_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          stall_decode = 1'b0;
  logic          flush_decode = 1'b0;
  logic          inst_valid = 1'b0;
  logic [31:0]   inst_fetch = '0;
  logic [AB-1:0] pc_inst = '0;
  logic [31:0]   instruction_decode;
  logic [AB-1:0] pc_decode;
  logic          valid_decode;
  logic          fetch_hold;
  logic          i_mem_hazard;
  logic          overflow;
  logic [31:0]   stall_cycles;
  logic [31:0]   flush_count;

  int testsRun = 0;
  int testsFailed = 0;

  entry_t        sbQueue[$];
  logic [31:0]   mInst;
  logic [AB-1:0] mPc;
  logic          mValid;
  int            mState;
  logic          mOverflow;
  int            mStall;
  int            mFlush;

  fetch_decode_pipe #(
    .CORE(0),
    .ADDRESS_BITS(AB),
    .NOP(NOPI)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .stall_decode       (stall_decode),
    .flush_decode       (flush_decode),
    .inst_valid         (inst_valid),
    .inst_fetch         (inst_fetch),
    .pc_inst            (pc_inst),
    .instruction_decode (instruction_decode),
    .pc_decode          (pc_decode),
    .valid_decode       (valid_decode),
    .fetch_hold         (fetch_hold),
    .i_mem_hazard       (i_mem_hazard),
    .overflow           (overflow),
    .stall_cycles       (stall_cycles),
    .flush_count        (flush_count)
  );

  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Statistics expectations depend on whether the counters are built in.
  function automatic logic [31:0] expStats(input int n);
`ifdef FETCH_DECODE_STATS_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  // Compares every registered output and the internal occupancy/state
  // against the bench's own model.
  task automatic checkRegs(input string where);
    checkOutput({where, ".instDecode"}, instruction_decode, mInst);
    checkOutput({where, ".pcDecode"}, pc_decode, mPc);
    checkOutput({where, ".validDecode"}, valid_decode, mValid);
    checkOutput({where, ".count"}, dut.fifoCount, sbQueue.size());
    checkOutput({where, ".state"}, dut.state_q, mState);
    checkOutput({where, ".overflow"}, overflow, mOverflow);
    checkOutput({where, ".stallCycles"}, stall_cycles, expStats(mStall));
    checkOutput({where, ".flushCount"}, flush_count, expStats(mFlush));
  endtask

  // Asynchronous reset mid-cycle; outputs are checked before any clock edge.
  task automatic doReset();
    stall_decode = 1'b0;
    flush_decode = 1'b0;
    inst_valid   = 1'b0;
    reset        = 1'b0;
    sbQueue.delete();
    mInst     = NOPI;
    mPc       = '0;
    mValid    = 1'b0;
    mState    = 0;
    mOverflow = 1'b0;
    mStall    = 0;
    mFlush    = 0;
    #1;
    checkRegs("reset");
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Drives one cycle, checks the combinational outputs before the edge,
  // then steps the model and checks the registered outputs after it.
  task automatic applyStimulus(input logic stall, input logic flush, input logic valid,
                               input logic [31:0] inst, input logic [AB-1:0] pc);
    entry_t e;
    logic   accepted;
    logic   expHold;
    logic   expHazard;
    stall_decode = stall;
    flush_decode = flush;
    inst_valid   = valid;
    inst_fetch   = inst;
    pc_inst      = pc;
    #1;
    expHold   = stall | (sbQueue.size() != 0) | (mState == 2);
    expHazard = (mState == 0) & !stall & (sbQueue.size() == 0) & !valid;
    checkOutput("fetchHold", fetch_hold, expHold);
    checkOutput("iMemHazard", i_mem_hazard, expHazard);
    @(posedge clock);
    #1;
    accepted = valid && (mState != 2);
    e.inst = inst;
    e.pc   = pc;
    if (flush) begin
      sbQueue.delete();
      mInst  = NOPI;
      mPc    = '0;
      mValid = 1'b0;
      mState = 2;
    end else if (stall) begin
      if (accepted) begin
        if (sbQueue.size() < 2) sbQueue.push_back(e);
        else mOverflow = 1'b1;
      end
      mState = 1;
    end else begin
      if (accepted) sbQueue.push_back(e);
      if (sbQueue.size() != 0) begin
        e      = sbQueue.pop_front();
        mInst  = e.inst;
        mPc    = e.pc;
        mValid = 1'b1;
      end else begin
        mInst  = NOPI;
        mPc    = '0;
        mValid = 1'b0;
      end
      mState = 0;
    end
    if (stall) mStall++;
    if (flush) mFlush++;
    checkRegs("cycle");
  endtask

  initial begin
    #3;
    doReset();

    // Direct path: one-cycle latency from I-memory to decode.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00A00093, 20'h4);
    checkOutput("directInst", instruction_decode, 32'h00A00093);

    // Stall three cycles with A arriving in the first; decode holds.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h00B00113, 20'h8);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 20'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 20'h0);
    checkOutput("heldInst", instruction_decode, 32'h00A00093);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 20'h0);
    checkOutput("skidInst", instruction_decode, 32'h00B00113);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 20'h0);

    // Flush, then a stale response B in the drop cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 20'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEAD00B3, 20'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 20'h0);

    // A few back-to-back direct fetches.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, $urandom, AB'(32'h100 + 4 * i));
    end

    // Three enqueues under stall: third overflows.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h11100093, 20'h20);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h22200093, 20'h24);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h33300093, 20'h28);
    checkOutput("overflowSet", overflow, 1'b1);
    // Full buffer drains while accepting a new response.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h44400093, 20'h2C);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 20'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 20'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 20'h0);

    // Fill to two, then flush and stall together: flush wins.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h55500093, 20'h30);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h66600093, 20'h34);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h77700093, 20'h38);
    checkOutput("flushStallState", dut.state_q, 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 20'h0);

    // Reset in the middle of a stall with a buffered entry.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h88800093, 20'h40);
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 20'h0);

    // Reset while in DROP.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 20'h0);
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h99900093, 20'h44);

    // Five stall cycles for the statistics counter.
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 20'h0);
    checkOutput("stallCycles5", stall_cycles, expStats(5));
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 20'h0);

    checkOutput("sbDrained", sbQueue.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_decode_pipe.md
FETCH_DECODE_PIPE -- requirements
Module: fetch_decode_pipe

Interface
REQ-001 Parameters SHALL be: CORE, default 0, core index; ADDRESS_BITS, default 20, PC width; NOP, default 32'h00000013, bubble instruction.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 stall_decode, flush_decode  input  1 each  pipeline control from the stall unit.
REQ-005 inst_valid  input  1  I-memory response valid this cycle.
REQ-006 inst_fetch  input  32  I-memory instruction.
REQ-007 pc_inst  input  ADDRESS_BITS  PC of inst_fetch.
REQ-008 instruction_decode  output  32  registered instruction presented to decode.
REQ-009 pc_decode  output  ADDRESS_BITS  registered PC presented to decode.
REQ-010 valid_decode  output  1  decode registers hold a real instruction.
REQ-011 fetch_hold  output  1  fetch SHALL NOT issue a new request this cycle.
REQ-012 i_mem_hazard  output  1  no instruction available for decode.
REQ-013 overflow  output  1  sticky skid-buffer overflow flag.
REQ-014 stall_cycles, flush_count  output  32 each  statistics counters.

Function
REQ-015 A 2-entry FIFO skid buffer SHALL hold {instruction, pc}, with a 2-bit count ranging 0..2.
REQ-016 The FSM SHALL have states RUN, STALL, and DROP.
REQ-017 RUN/STALL next state: flush_decode -> DROP; stall_decode -> STALL; else RUN.
REQ-018 DROP next state: flush_decode -> DROP; else stall_decode ? STALL : RUN.
REQ-019 Advance (not stalled, not flushed), count>0: decode regs SHALL load the FIFO head, valid_decode=1; a same-cycle inst_valid SHALL be enqueued (count unchanged).
REQ-020 Advance, count=0, inst_valid=1: decode regs SHALL load inst_fetch/pc_inst directly, valid_decode=1 (1-cycle latency).
REQ-021 Advance, count=0, inst_valid=0: decode regs SHALL load NOP, pc 0, valid_decode=0.
REQ-022 stall_decode=1: decode regs SHALL hold; inst_valid SHALL enqueue.
REQ-023 Enqueue at count=2: the entry SHALL be dropped, overflow set, and count kept at 2.
REQ-024 flush_decode=1: decode regs <= NOP/0/valid 0, FIFO cleared; the next cycle (state DROP) SHALL discard inst_valid.
REQ-025 Simultaneous flush_decode and stall_decode: flush SHALL win.
REQ-026 fetch_hold = stall_decode | (count!=0) | (state==DROP), combinational.
REQ-027 i_mem_hazard = (state==RUN) & ~stall_decode & (count==0) & ~inst_valid, combinational.
REQ-028 FIFO pointers SHALL wrap modulo 2.

Reset
REQ-029 On reset low, the block SHALL asynchronously set: instruction_decode=NOP, pc_decode=0, valid_decode=0, count=0, pointers=0, state RUN, overflow=0, counters 0.
REQ-030 Reset mid-stall or mid-drop SHALL discard all buffered entries.

Configuration
REQ-031 With FETCH_DECODE_STATS_EN defined: stall_cycles SHALL increment each cycle stall_decode=1 and flush_count each cycle flush_decode=1, both saturating at 32'hFFFFFFFF.
REQ-032 With FETCH_DECODE_STATS_EN undefined: stall_cycles and flush_count SHALL be constant 0 and no counter registers exist.

Structure
REQ-033 The shared package SHALL hold the FSM state encodings (RUN=2'd0, STALL=2'd1, DROP=2'd2) and the default NOP constant.
REQ-034 The skid buffer SHALL be sub-module fd_skid_fifo (push, pop, clear, count, head outputs).

Verification
REQ-035 Reset, then inst_valid=1, inst=32'h00A00093, pc=0x4 -> next cycle instruction_decode=32'h00A00093, pc_decode=0x4, valid_decode=1.
REQ-036 stall_decode=1 for 3 cycles with inst_valid=1 (inst A) in the first cycle -> decode regs held, count=1, fetch_hold=1; after release, A presented next cycle, then count=0.
REQ-037 flush_decode=1 then inst_valid=1 (stale inst B) in the next cycle -> decode regs NOP/valid 0 for 2 cycles, B never presented, flush_count=1.
REQ-038 Force 3 enqueues under stall -> count=2, overflow=1 sticky until reset.
REQ-039 flush_decode=1 and stall_decode=1 in the same cycle with count=2 -> FIFO empty, valid_decode=0, state DROP.
REQ-040 With FETCH_DECODE_STATS_EN: 5 stall cycles -> stall_cycles=5; without the macro -> stall_cycles=0.
